// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, sizing helper and defaults for the UART TX arbiter
package uart_pkg;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;
    localparam int DEF_LOCK_TIMEOUT = 4096;
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: byte requester bus shared by NREQ requesters
interface uart_tx_arbiter_if #(parameter int NREQ = 4);
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    modport master (output req_valid, req_data, req_last, input req_ready);
    modport slave  (input req_valid, req_data, req_last, output req_ready);
endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin picker, first request at or after ptr
module uart_rr_pick import uart_pkg::*; #(
    parameter int N = 4,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);
    logic [W-1:0] j;
    always_comb begin
        gnt = '0;
        idx = '0;
        j = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = W'((int'(ptr) + k) % N);
            if (req[j]) begin
                gnt = '0;
                gnt[j] = 1'b1;
                idx = j;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart_tx among NREQ requesters with frame lock
module uart_tx_arbiter import uart_pkg::*; #(
    parameter int NREQ = 4,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int IW = clog2(NREQ)
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_arbiter_if.slave req,
    output logic            tx_start,
    output logic [7:0]      tx_din,
    input  logic            tx_done_tick,
    output logic [IW-1:0]   grant_id,
    output logic            busy,
    output logic            lock_timeout
);
    localparam int CW = clog2(LOCK_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_TIMEOUT > 0 ? LOCK_TIMEOUT - 1 : 0);
    logic [1:0]      state_q, state_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_din_q, tx_din_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic            busy_q, busy_d;
    logic            lock_timeout_q, lock_timeout_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            lock_q, lock_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      bytes [NREQ];
    logic [NREQ-1:0] pick_gnt, hold_rdy;
    logic [IW-1:0]   pick_idx, sel, nxt_owner;
    logic            accept, timeout_hit;
    for (genvar g = 0; g < NREQ; g++) begin : g_byte
        assign bytes[g] = req.req_data[8*g +: 8];
    end
    uart_rr_pick #(.N(NREQ), .W(IW)) u_pick (
        .req (req.req_valid),
        .ptr (rr_ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );
    always_comb begin
        hold_rdy = '0;
        hold_rdy[grant_id_q] = req.req_valid[grant_id_q];
    end
    // ready is forced low while reset is asserted so nothing is offered from IDLE
    assign req.req_ready = !reset ? '0 : (state_q == IDLE) ? pick_gnt : (state_q == HOLD) ? hold_rdy : '0;
    assign sel         = (state_q == IDLE) ? pick_idx : grant_id_q;
    assign accept      = |(req.req_valid & req.req_ready);
    assign nxt_owner   = (grant_id_q == IW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;
    assign timeout_hit = (LOCK_TIMEOUT > 0) && (cnt_q == CNT_LAST);
    always_comb begin
        state_d = state_q;
        tx_din_d = tx_din_q;
        grant_id_d = grant_id_q;
        rr_ptr_d = rr_ptr_q;
        lock_d = lock_q;
        cnt_d = cnt_q;
        lock_timeout_d = 1'b0;
        case (state_q)
            IDLE, HOLD: begin
                if (accept) begin
                    state_d = START;
                    tx_din_d = bytes[sel];
                    grant_id_d = sel;
                    lock_d = ~req.req_last[sel];
                end else if (state_q == HOLD) begin
                    if (timeout_hit) begin
                        state_d = IDLE;
                        lock_d = 1'b0;
                        rr_ptr_d = nxt_owner;
                        lock_timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (tx_done_tick) begin
                    state_d = lock_q ? HOLD : IDLE;
                    rr_ptr_d = lock_q ? rr_ptr_q : nxt_owner;
                    cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign tx_start_d = (state_d == START);
    assign busy_d     = (state_d != IDLE);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tx_start_q <= 1'b0;
            tx_din_q <= '0;
            grant_id_q <= '0;
            busy_q <= 1'b0;
            lock_timeout_q <= 1'b0;
            rr_ptr_q <= '0;
            lock_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            tx_start_q <= tx_start_d;
            tx_din_q <= tx_din_d;
            grant_id_q <= grant_id_d;
            busy_q <= busy_d;
            lock_timeout_q <= lock_timeout_d;
            rr_ptr_q <= rr_ptr_d;
            lock_q <= lock_d;
            cnt_q <= cnt_d;
        end
    end
    assign tx_start     = tx_start_q;
    assign tx_din       = tx_din_q;
    assign grant_id     = grant_id_q;
    assign busy         = busy_q;
    assign lock_timeout = lock_timeout_q;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter between NREQ byte requesters using round-robin arbitration.
- Optional frame lock keeps the grant on one requester until its last byte is sent, so multi-byte messages are never interleaved.
- Sits between the requester logic and uart_tx: drives tx_start/din and consumes tx_done_tick.
- Baud tick generation is outside this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LOCK_TIMEOUT, 4096, clk cycles a locked grant waits in HOLD for the owner's next byte before the lock is forcibly released; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- req_valid  input  NREQ  per-requester byte available.
- req_data  input  8*NREQ  byte of requester i at bits [8i+7:8i].
- req_last  input  NREQ  byte is the last of its frame; 1 means no lock.
- req_ready  output  NREQ  one-hot accept; a byte transfers when req_valid[i] & req_ready[i].
- tx_start  output  1  one-cycle start pulse to uart_tx.
- tx_din  output  8  byte to uart_tx; held stable from tx_start until tx_done_tick.
- tx_done_tick  input  1  one-cycle completion pulse from uart_tx.
- grant_id  output  clog2(NREQ)  index of the current or last owner.
- busy  output  1  high in every state except IDLE.
- lock_timeout  output  1  one-cycle pulse when a lock is forcibly released.

Behaviour:
- Reset values: state=IDLE; tx_start=0; tx_din=0; grant_id=0; busy=0; lock_timeout=0; rr_ptr=0; lock=0; timeout counter=0; req_ready=0.
- Registered outputs: tx_start, tx_din, grant_id, busy, lock_timeout. req_ready is combinational from the state, rr_ptr and req_valid.
- States:
  - IDLE: winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, … modulo NREQ. req_ready[winner]=1 in this cycle. On accept, capture tx_din=req_data[winner], grant_id=winner, lock=~req_last[winner], and go to START. With no valid request, stay in IDLE with req_ready=0.
  - START: tx_start=1 for exactly this one cycle, then go to WAIT. req_ready=0.
  - WAIT: hold tx_din. On tx_done_tick:
    - if lock=1, go to HOLD and clear the timeout counter;
    - else set rr_ptr=(grant_id+1) mod NREQ and go to IDLE.
    - req_ready=0 throughout.
  - HOLD: req_ready[grant_id]=req_valid[grant_id]; all other requesters are ignored. On accept, capture data, set lock=~req_last, and go to START. Otherwise increment the counter. When the counter reaches LOCK_TIMEOUT-1 (with LOCK_TIMEOUT>0), pulse lock_timeout, clear lock, set rr_ptr=grant_id+1 mod NREQ, and go to IDLE.
- Latency:
  - valid accepted in IDLE at cycle 0 gives tx_start at cycle 1.
  - tx_done_tick at cycle t gives IDLE at t+1, accept at t+1 and tx_start at t+2.
  - Locked path: HOLD at t+1, same timing.
- tx_done_tick outside WAIT is ignored.
- In the same cycle, an accept in HOLD takes priority over the timeout.
- req_valid dropping before accept has no effect; no byte is captured.
- NREQ=1 degenerates to pass-through with the same timing.
- Reset assertion mid-frame (any state) returns to IDLE immediately with tx_start=0. The partially sent byte is abandoned; uart_tx is reset by the same signal.
- rr_ptr arithmetic wraps modulo NREQ, so no out-of-range index is produced for non-power-of-2 NREQ.

Decomposition:
- Package uart_pkg: state encoding localparams IDLE/START/WAIT/HOLD (2-bit), clog2 function, default LOCK_TIMEOUT.
- Sub-module uart_rr_pick: combinational round-robin picker.
  - Inputs: req[NREQ], ptr.
  - Outputs: one-hot grant and index.
  - Instantiated once and reusable by future RX-side schedulers.

Test Plan:
- Single requester: req_valid=4'b0010, data 0x5A, last=1 → req_ready=4'b0010 the same cycle, tx_start the next cycle, tx_din=0x5A held until tx_done_tick, busy drops one cycle later.
- Fairness: all four valid continuously, last=1 → grant order 0,1,2,3,0,… with exactly one tx_start per tx_done_tick.
- Frame lock: requester 2 sends 0x01(last=0), 0x02(last=0), 0x03(last=1) while requesters 0, 1 and 3 are valid → all three bytes are sent consecutively before any other grant; the next grant is 3.
- Lock timeout with LOCK_TIMEOUT=16: requester 1 sends last=0 then drops valid → lock_timeout pulses 16 cycles after entering HOLD, and requester 2 (valid) is granted next.
- Reset mid-WAIT: drive reset=0 during byte 0xA5 → all outputs go to reset values at once; after release, a pending request from requester 3 is granted first with rr_ptr=0 search order.
- Spurious tx_done_tick asserted in IDLE and START → no state change, and no duplicate or missing tx_start.
